// File: rtl/csr_pkg.sv
// Shared constants and state encoding for the machine-mode trap/return sequencer.
// The mret path (R_STATUS/R_JUMP) is only compiled when CSR_TRAP_MRET_EN is defined.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int unsigned CAUSE_ECALL_M    = 11;
    localparam int unsigned CAUSE_BREAKPOINT = 3;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_HI = 12;
    localparam int unsigned MSTATUS_MPP_LO = 11;

    typedef enum logic [2:0] {
        StIdle,
        StTEpc,
        StTCause,
        StTStatus,
        StTJump
`ifdef CSR_TRAP_MRET_EN
        ,
        StRStatus,
        StRJump
`endif
    } trap_state_t;

    // Jump states are the only cycles where the redirect target is read from the array.
    function automatic logic is_jump_state(trap_state_t s);
`ifdef CSR_TRAP_MRET_EN
        return (s == StTJump) || (s == StRJump);
`else
        return s == StTJump;
`endif
    endfunction

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// Bundles the front-end request/redirect signals and the CSR array ports of csr_trap_ctrl.
// slave is the sequencer side; master is the core/array environment side.
interface csr_trap_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            exc_valid;
    logic [XLEN-1:0] exc_cause;
    logic [XLEN-1:0] exc_pc;
    logic            exc_ready;
    logic            mret_valid;
    logic            inst_wr_valid;
    logic [11:0]     inst_wr_addr;
    logic [XLEN-1:0] inst_wr_data;
    logic [11:0]     inst_rd_addr;
    logic            inst_ready;
    logic            csr_wr_en;
    logic [11:0]     csr_wr_addr;
    logic [XLEN-1:0] csr_wr_data;
    logic [11:0]     csr_rd_addr;
    logic [XLEN-1:0] csr_rd_data;
    logic            busy;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport slave (
        input  exc_valid, exc_cause, exc_pc, mret_valid,
        input  inst_wr_valid, inst_wr_addr, inst_wr_data, inst_rd_addr,
        input  csr_rd_data,
        output exc_ready, inst_ready, csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr,
        output busy, redirect_valid, redirect_pc
    );

    modport master (
        output exc_valid, exc_cause, exc_pc, mret_valid,
        output inst_wr_valid, inst_wr_addr, inst_wr_data, inst_rd_addr,
        output csr_rd_data,
        input  exc_ready, inst_ready, csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr,
        input  busy, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/csr_wr_mux.sv
// Selects the CSR array write (instruction vs. trap sequencer) and read address by state.
// mstatus return update is compiled only with CSR_TRAP_MRET_EN.
module csr_wr_mux
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  trap_state_t     state_i,
    input  logic            inst_accept_i,
    input  logic            inst_wr_valid_i,
    input  logic [11:0]     inst_wr_addr_i,
    input  logic [XLEN-1:0] inst_wr_data_i,
    input  logic [11:0]     inst_rd_addr_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic [XLEN-1:0] cause_i,
    input  logic [XLEN-1:0] csr_rd_data_i,
    output logic            csr_wr_en_o,
    output logic [11:0]     csr_wr_addr_o,
    output logic [XLEN-1:0] csr_wr_data_o,
    output logic [11:0]     csr_rd_addr_o
);

    logic [XLEN-1:0] status_trap;

    always_comb begin
        status_trap = csr_rd_data_i;
        status_trap[MSTATUS_MPIE] = csr_rd_data_i[MSTATUS_MIE];
        status_trap[MSTATUS_MIE] = 1'b0;
        status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

`ifdef CSR_TRAP_MRET_EN
    logic [XLEN-1:0] status_ret;

    always_comb begin
        status_ret = csr_rd_data_i;
        status_ret[MSTATUS_MIE] = csr_rd_data_i[MSTATUS_MPIE];
        status_ret[MSTATUS_MPIE] = 1'b1;
        status_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end
`endif

    // Idle write port is zeroed unless an accepted instruction write is present.
    always_comb begin
        csr_wr_en_o   = 1'b0;
        csr_wr_addr_o = '0;
        csr_wr_data_o = '0;
        csr_rd_addr_o = inst_rd_addr_i;
        unique case (state_i)
            StIdle: begin
                if (inst_accept_i && inst_wr_valid_i) begin
                    csr_wr_en_o   = 1'b1;
                    csr_wr_addr_o = inst_wr_addr_i;
                    csr_wr_data_o = inst_wr_data_i;
                end
            end
            StTEpc: begin
                csr_wr_en_o   = 1'b1;
                csr_wr_addr_o = CSR_MEPC;
                csr_wr_data_o = epc_i;
            end
            StTCause: begin
                csr_wr_en_o   = 1'b1;
                csr_wr_addr_o = CSR_MCAUSE;
                csr_wr_data_o = cause_i;
            end
            StTStatus: begin
                csr_rd_addr_o = CSR_MSTATUS;
                csr_wr_en_o   = 1'b1;
                csr_wr_addr_o = CSR_MSTATUS;
                csr_wr_data_o = status_trap;
            end
            StTJump: begin
                csr_rd_addr_o = CSR_MTVEC;
            end
`ifdef CSR_TRAP_MRET_EN
            StRStatus: begin
                csr_rd_addr_o = CSR_MSTATUS;
                csr_wr_en_o   = 1'b1;
                csr_wr_addr_o = CSR_MSTATUS;
                csr_wr_data_o = status_ret;
            end
            StRJump: begin
                csr_rd_addr_o = CSR_MEPC;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap entry / mret sequencer owning the CSR array write and read-address ports.
// Define CSR_TRAP_MRET_EN to compile the mret return path.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MTVEC_ALIGN = 2
) (
    input logic               clk,
    input logic               rstn,
    csr_trap_ctrl_if.slave    bus
);

    localparam logic [XLEN-1:0] AlignMask = {XLEN{1'b1}} << MTVEC_ALIGN;

    trap_state_t     state_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] cause_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            idle;
    logic            inst_accept;
    logic [XLEN-1:0] jump_target;

    assign idle        = (state_q == StIdle);
    assign jump_target = bus.csr_rd_data & AlignMask;

`ifdef CSR_TRAP_MRET_EN
    assign inst_accept = idle && !bus.exc_valid && !bus.mret_valid;
`else
    logic unused_mret;
    assign unused_mret = bus.mret_valid;
    assign inst_accept = idle && !bus.exc_valid;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= StIdle;
            epc_q            <= '0;
            cause_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= 1'b0;
            if (redirect_valid_q) begin
                redirect_pc_q <= jump_target;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.exc_valid) begin
                        state_q <= StTEpc;
                        epc_q   <= bus.exc_pc;
                        cause_q <= bus.exc_cause;
                    end
`ifdef CSR_TRAP_MRET_EN
                    else if (bus.mret_valid) begin
                        state_q <= StRStatus;
                    end
`endif
                end
                StTEpc:   state_q <= StTCause;
                StTCause: state_q <= StTStatus;
                StTStatus: begin
                    state_q          <= StTJump;
                    redirect_valid_q <= 1'b1;
                end
                StTJump:  state_q <= StIdle;
`ifdef CSR_TRAP_MRET_EN
                StRStatus: begin
                    state_q          <= StRJump;
                    redirect_valid_q <= 1'b1;
                end
                StRJump:  state_q <= StIdle;
`endif
                default:  state_q <= StIdle;
            endcase
        end
    end

    // The target comes from the same-cycle array read; the register only holds it afterwards.
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_valid_q ? jump_target : redirect_pc_q;
    assign bus.busy           = !idle;
    assign bus.exc_ready      = idle;
    assign bus.inst_ready     = inst_accept;

    logic jump_unused;
    assign jump_unused = is_jump_state(state_q);

    csr_wr_mux #(
        .XLEN (XLEN)
    ) u_wr_mux (
        .state_i         (state_q),
        .inst_accept_i   (inst_accept),
        .inst_wr_valid_i (bus.inst_wr_valid),
        .inst_wr_addr_i  (bus.inst_wr_addr),
        .inst_wr_data_i  (bus.inst_wr_data),
        .inst_rd_addr_i  (bus.inst_rd_addr),
        .epc_i           (epc_q),
        .cause_i         (cause_q),
        .csr_rd_data_i   (bus.csr_rd_data),
        .csr_wr_en_o     (bus.csr_wr_en),
        .csr_wr_addr_o   (bus.csr_wr_addr),
        .csr_wr_data_o   (bus.csr_wr_data),
        .csr_rd_addr_o   (bus.csr_rd_addr)
    );

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a small behavioural CSR array.
// Expectations for the mret path follow CSR_TRAP_MRET_EN.
module tb_csr_trap_ctrl;
    import csr_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    csr_trap_ctrl_if #(.XLEN(32)) bus ();

    csr_trap_ctrl #(
        .XLEN        (32),
        .MTVEC_ALIGN (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] m_mstatus = '0;
    logic [31:0] m_mtvec   = '0;
    logic [31:0] m_mepc    = '0;
    logic [31:0] m_mcause  = '0;

    always_comb begin
        case (bus.csr_rd_addr)
            CSR_MSTATUS: bus.csr_rd_data = m_mstatus;
            CSR_MTVEC:   bus.csr_rd_data = m_mtvec;
            CSR_MEPC:    bus.csr_rd_data = m_mepc;
            CSR_MCAUSE:  bus.csr_rd_data = m_mcause;
            default:     bus.csr_rd_data = '0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.csr_wr_en) begin
            case (bus.csr_wr_addr)
                CSR_MSTATUS: m_mstatus <= bus.csr_wr_data;
                CSR_MTVEC:   m_mtvec   <= bus.csr_wr_data;
                CSR_MEPC:    m_mepc    <= bus.csr_wr_data;
                CSR_MCAUSE:  m_mcause  <= bus.csr_wr_data;
                default: ;
            endcase
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_wr(input string name, input logic en, input logic [11:0] addr,
                          input logic [31:0] data);
        chk({name, ".wr_en"}, {31'd0, bus.csr_wr_en}, {31'd0, en});
        chk({name, ".wr_addr"}, {20'd0, bus.csr_wr_addr}, {20'd0, addr});
        chk({name, ".wr_data"}, bus.csr_wr_data, data);
    endtask

    task automatic chk_flags(input string name, input logic busy, input logic rv,
                             input logic [31:0] rpc);
        chk({name, ".busy"}, {31'd0, bus.busy}, {31'd0, busy});
        chk({name, ".exc_ready"}, {31'd0, bus.exc_ready}, {31'd0, !busy});
        chk({name, ".redirect_valid"}, {31'd0, bus.redirect_valid}, {31'd0, rv});
        chk({name, ".redirect_pc"}, bus.redirect_pc, rpc);
    endtask

    task automatic idle_inputs();
        bus.exc_valid     = 1'b0;
        bus.exc_cause     = '0;
        bus.exc_pc        = '0;
        bus.mret_valid    = 1'b0;
        bus.inst_wr_valid = 1'b0;
        bus.inst_wr_addr  = '0;
        bus.inst_wr_data  = '0;
        bus.inst_rd_addr  = '0;
    endtask

    // Inputs change on the falling edge; checks follow 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    typedef struct {
        logic        wr_valid;
        logic [11:0] wr_addr;
        logic [31:0] wr_data;
        logic [11:0] rd_addr;
        logic        exp_ready;
        logic        exp_en;
        logic [11:0] exp_addr;
        logic [31:0] exp_data;
        logic [11:0] exp_rd;
    } vec_t;

    vec_t vecs[7];
    logic [31:0] exp_status;

    initial begin
        vecs[0] = '{1'b1, 12'h305, 32'h8000_0100, 12'h305, 1'b1, 1'b1, 12'h305, 32'h8000_0100, 12'h305};
        vecs[1] = '{1'b1, 12'h305, 32'h8000_0101, 12'h300, 1'b1, 1'b1, 12'h305, 32'h8000_0101, 12'h300};
        vecs[2] = '{1'b1, 12'h300, 32'h0000_0008, 12'h341, 1'b1, 1'b1, 12'h300, 32'h0000_0008, 12'h341};
        vecs[3] = '{1'b0, 12'h342, 32'h1234_5678, 12'h342, 1'b1, 1'b0, 12'h000, 32'h0000_0000, 12'h342};
        vecs[4] = '{1'b1, 12'h340, 32'hdead_beef, 12'h300, 1'b1, 1'b1, 12'h340, 32'hdead_beef, 12'h300};
        vecs[5] = '{1'b1, 12'h342, 32'h0000_0000, 12'h305, 1'b1, 1'b1, 12'h342, 32'h0000_0000, 12'h305};
        vecs[6] = '{1'b1, 12'h341, 32'h1111_1111, 12'h7c0, 1'b1, 1'b1, 12'h341, 32'h1111_1111, 12'h7c0};

        rstn = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        #1;
        chk_flags("reset", 1'b0, 1'b0, 32'h0);
        chk_wr("reset", 1'b0, 12'h000, 32'h0);
        chk("reset.inst_ready", {31'd0, bus.inst_ready}, 32'd1);
        rstn = 1'b1;

        // Idle pass-through table
        foreach (vecs[i]) begin
            next_cycle();
            bus.inst_wr_valid = vecs[i].wr_valid;
            bus.inst_wr_addr  = vecs[i].wr_addr;
            bus.inst_wr_data  = vecs[i].wr_data;
            bus.inst_rd_addr  = vecs[i].rd_addr;
            #1;
            chk($sformatf("vec%0d.inst_ready", i), {31'd0, bus.inst_ready},
                {31'd0, vecs[i].exp_ready});
            chk_wr($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_addr, vecs[i].exp_data);
            chk($sformatf("vec%0d.rd_addr", i), {20'd0, bus.csr_rd_addr}, {20'd0, vecs[i].exp_rd});
        end
        next_cycle();
        idle_inputs();

        // Ecall: mstatus 0x8, mtvec 0x80000101
        bus.exc_valid = 1'b1;
        bus.exc_pc    = 32'h8000_0040;
        bus.exc_cause = CAUSE_ECALL_M;
        #1;
        chk("ecall.N.inst_ready", {31'd0, bus.inst_ready}, 32'd0);
        chk_wr("ecall.N", 1'b0, 12'h000, 32'h0);
        next_cycle();
        idle_inputs();
        #1;
        chk_flags("ecall.N1", 1'b1, 1'b0, 32'h0);
        chk_wr("ecall.N1", 1'b1, 12'h341, 32'h8000_0040);
        chk("ecall.N1.inst_ready", {31'd0, bus.inst_ready}, 32'd0);
        next_cycle();
        #1;
        chk_wr("ecall.N2", 1'b1, 12'h342, 32'd11);
        next_cycle();
        #1;
        chk_wr("ecall.N3", 1'b1, 12'h300, 32'h0000_1880);
        chk("ecall.N3.rd_addr", {20'd0, bus.csr_rd_addr}, 32'h300);
        next_cycle();
        #1;
        chk_flags("ecall.N4", 1'b1, 1'b1, 32'h8000_0100);
        chk_wr("ecall.N4", 1'b0, 12'h000, 32'h0);
        next_cycle();
        #1;
        chk_flags("ecall.N5", 1'b0, 1'b0, 32'h8000_0100);
        chk("ecall.mepc", m_mepc, 32'h8000_0040);
        chk("ecall.mcause", m_mcause, 32'd11);
        chk("ecall.mstatus", m_mstatus, 32'h0000_1880);

`ifdef CSR_TRAP_MRET_EN
        // mret returning from that ecall
        bus.mret_valid = 1'b1;
        #1;
        chk("mret.N.inst_ready", {31'd0, bus.inst_ready}, 32'd0);
        next_cycle();
        idle_inputs();
        #1;
        chk_flags("mret.N1", 1'b1, 1'b0, 32'h8000_0100);
        chk_wr("mret.N1", 1'b1, 12'h300, 32'h0000_1888);
        next_cycle();
        #1;
        chk_flags("mret.N2", 1'b1, 1'b1, 32'h8000_0040);
        chk_wr("mret.N2", 1'b0, 12'h000, 32'h0);
        next_cycle();
        #1;
        chk_flags("mret.N3", 1'b0, 1'b0, 32'h8000_0040);
        chk("mret.mstatus", m_mstatus, 32'h0000_1888);
        exp_status = 32'h0000_1880;
`else
        exp_status = 32'h0000_1800;
`endif

        // Trap, mret and instruction write all in one cycle; instruction write held
        next_cycle();
        bus.exc_valid     = 1'b1;
        bus.exc_pc        = 32'h8000_0084;
        bus.exc_cause     = CAUSE_BREAKPOINT;
        bus.mret_valid    = 1'b1;
        bus.inst_wr_valid = 1'b1;
        bus.inst_wr_addr  = 12'h340;
        bus.inst_wr_data  = 32'hcafe_f00d;
        #1;
        chk("combo.N.inst_ready", {31'd0, bus.inst_ready}, 32'd0);
        chk_wr("combo.N", 1'b0, 12'h000, 32'h0);
        next_cycle();
        bus.exc_valid  = 1'b0;
        bus.mret_valid = 1'b0;
        #1;
        chk("combo.N1.inst_ready", {31'd0, bus.inst_ready}, 32'd0);
        chk_wr("combo.N1", 1'b1, 12'h341, 32'h8000_0084);
        next_cycle();
        #1;
        chk_wr("combo.N2", 1'b1, 12'h342, 32'd3);
        next_cycle();
        #1;
        chk_wr("combo.N3", 1'b1, 12'h300, exp_status);
        next_cycle();
        #1;
        chk_flags("combo.N4", 1'b1, 1'b1, 32'h8000_0100);
        chk("combo.N4.inst_ready", {31'd0, bus.inst_ready}, 32'd0);
        next_cycle();
        #1;
        chk("combo.N5.inst_ready", {31'd0, bus.inst_ready}, 32'd1);
        chk_wr("combo.N5", 1'b1, 12'h340, 32'hcafe_f00d);
        next_cycle();
        idle_inputs();
        #1;
        chk_flags("combo.N6", 1'b0, 1'b0, 32'h8000_0100);
        chk("combo.mstatus", m_mstatus, exp_status);

        // Reset asserted while in T_CAUSE
        next_cycle();
        bus.exc_valid = 1'b1;
        bus.exc_pc    = 32'h8000_0200;
        bus.exc_cause = CAUSE_ECALL_M;
        next_cycle();
        idle_inputs();
        #1;
        chk_wr("rst.N1", 1'b1, 12'h341, 32'h8000_0200);
        next_cycle();
        #1;
        chk_wr("rst.N2", 1'b1, 12'h342, 32'd11);
        rstn = 1'b0;
        #1;
        chk_flags("rst.async", 1'b0, 1'b0, 32'h0);
        chk_wr("rst.async", 1'b0, 12'h000, 32'h0);
        next_cycle();
        rstn = 1'b1;
        #1;
        chk("rst.mepc", m_mepc, 32'h8000_0200);
        chk("rst.mcause", m_mcause, 32'd3);
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            #1;
            chk_flags($sformatf("rst.after%0d", c), 1'b0, 1'b0, 32'h0);
        end

`ifndef CSR_TRAP_MRET_EN
        // mret is ignored in this build
        next_cycle();
        bus.mret_valid = 1'b1;
        #1;
        chk("nomret.inst_ready", {31'd0, bus.inst_ready}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            bus.mret_valid = 1'b0;
            #1;
            chk_flags($sformatf("nomret.%0d", c), 1'b0, 1'b0, 32'h0);
            chk_wr($sformatf("nomret.%0d", c), 1'b0, 12'h000, 32'h0);
        end
`endif

        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Trap and return sequencer for the machine-mode CSR file. Sits between the decode/execute stage and the CSR register array and owns the array's single write port and its read-address port. Arbitrates ordinary CSR-instruction writes against multi-cycle trap entry (ecall/ebreak) and trap return (mret). Sequences the mepc, mcause and mstatus updates and produces the PC redirect to mtvec or mepc.

## Interface
- Parameters
  - XLEN, 32, data width of CSRs and PCs.
  - MTVEC_ALIGN, 2, number of low target bits forced to zero on redirect (direct mode).
- Ports
  - clk  in  1  core clock.
  - rstn  in  1  asynchronous, active-low reset.
  - exc_valid  in  1  trap request (ecall/ebreak retiring); sampled only when exc_ready.
  - exc_cause  in  XLEN  mcause value for the trap (11 = ecall-M, 3 = breakpoint).
  - exc_pc  in  XLEN  PC of the trapping instruction.
  - exc_ready  out  1  high only in IDLE.
  - mret_valid  in  1  mret retiring; sampled only when exc_ready.
  - inst_wr_valid  in  1  CSR-instruction write request.
  - inst_wr_addr  in  12  CSR address for that write.
  - inst_wr_data  in  XLEN  write data for that request.
  - inst_rd_addr  in  12  CSR address the instruction is reading.
  - inst_ready  out  1  instruction write accepted this cycle.
  - csr_wr_en  out  1  CSR array write enable.
  - csr_wr_addr  out  12  CSR array write address.
  - csr_wr_data  out  XLEN  CSR array write data.
  - csr_rd_addr  out  12  CSR array read address.
  - csr_rd_data  in  XLEN  combinational read data for csr_rd_addr.
  - busy  out  1  sequence in progress; front end must stall.
  - redirect_valid  out  1  one-cycle pulse; fetch must jump.
  - redirect_pc  out  XLEN  jump target.

## Operation
- States: IDLE, T_EPC, T_CAUSE, T_STATUS, T_JUMP, R_STATUS, R_JUMP.
- IDLE
  - exc_valid goes to T_EPC. It latches exc_pc and exc_cause.
  - If exc_valid is low and mret_valid is high, go to R_STATUS.
  - If both exc_valid and mret_valid are high, exc_valid wins and mret is dropped.
  - In IDLE, csr_rd_addr = inst_rd_addr.
  - In IDLE, the write port passes inst_wr_* through.
  - inst_ready = !exc_valid && !mret_valid, i.e. a trap in the same cycle blocks the instruction write.
- T_EPC: write mepc (0x341) with the latched pc.
- T_CAUSE: write mcause (0x342) with the latched cause.
- T_STATUS
  - Read mstatus (0x300).
  - Write it back with MPIE[7] = old MIE[3], MIE[3] = 0, MPP[12:11] = 2'b11.
  - Other bits are unchanged.
- T_JUMP
  - Read mtvec (0x305).
  - redirect_pc = csr_rd_data with the low MTVEC_ALIGN bits cleared.
  - Assert redirect_valid, no write, then go to IDLE.
- R_STATUS
  - Read and write mstatus with MIE[3] = old MPIE[7], MPIE[7] = 1, MPP = 2'b11.
- R_JUMP: read mepc, redirect_pc = csr_rd_data with low bits cleared, redirect_valid, then go to IDLE.
- Outside IDLE:
  - inst_ready = 0.
  - inst_wr_valid is ignored; the requester must hold it.
  - busy = 1.
- Write-port outputs are combinational from state.
- The latched pc and cause are the only datapath registers.

## Timing
- Reset values: state IDLE, csr_wr_en 0, csr_wr_addr 0, csr_wr_data 0, redirect_valid 0, redirect_pc 0, busy 0, exc_ready 1, latched pc/cause 0.
- Trap latency: request accepted in cycle N; mepc written N+1, mcause N+2, mstatus N+3; redirect_valid in N+4.
- mret latency: accepted N; mstatus written N+1; redirect_valid in N+2.
- exc_ready is high again the cycle after redirect_valid.
- A back-to-back trap may be accepted in that cycle.
- redirect_pc is registered with redirect_valid and holds its value until the next redirect.
- Reset mid-sequence:
  - The FSM returns to IDLE immediately and no redirect is issued.
  - CSRs already written are not rolled back.
- An instruction write to mepc/mcause/mstatus in IDLE completes in its own cycle, before any later trap write.

## Configuration
- CSR_TRAP_MRET_EN
  - Defined: R_STATUS/R_JUMP exist and mret behaves as above.
  - Undefined: those states are not compiled. mret_valid is ignored (no state change, no redirect) and exc_ready stays high in IDLE.

## Structure
- Package csr_pkg holds:
  - CSR address constants CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE.
  - Cause constants CAUSE_ECALL_M = 11 and CAUSE_BREAKPOINT = 3.
  - mstatus bit indices MIE = 3, MPIE = 7, MPP = 12:11.
  - The state enum trap_state_t.
- One sub-module, csr_wr_mux, selects the instruction write versus the FSM-generated write and the read address from the current state.

## Test plan
- Reset then idle: all outputs at reset values, exc_ready = 1, inst_wr pass-through of addr 0x305 with data 0x80000100 gives csr_wr_en = 1 the same cycle.
- Ecall:
  - Stimulus: exc_pc 0x80000040, cause 11, mtvec 0x80000101, mstatus 0x8.
  - Response: mepc = 0x80000040, mcause = 11, mstatus = 0x1880, redirect_pc = 0x80000100 at N+4.
- mret after that ecall: mstatus becomes 0x1888 at N+1, redirect_pc = 0x80000040 at N+2.
- Trap, mret and inst write all valid in the same cycle: ecall sequence runs, inst_ready = 0, the mret produces no redirect, and the inst write lands after returning to IDLE.
- rstn low in T_CAUSE: next cycle IDLE, mepc updated, mcause unchanged, redirect_valid never asserted.
- CSR_TRAP_MRET_EN undefined: mret_valid pulse gives no writes, no redirect and busy = 0.
